// File: rtl/ghr_ckpt_ctrl.sv
// Speculative/architectural global-history tracker with per-branch checkpoints; state updates one cycle after request.
// Predictions stall via pred_ready while full or during a recovery; commit and recover always accepted.
module ghr_ckpt_ctrl #(
    parameter int GHR_WIDTH = 5,
    parameter int DEPTH     = 8,
    parameter int TAG_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pred_valid,
    input  logic                 pred_taken,
    output logic                 pred_ready,
    output logic [TAG_WIDTH-1:0] pred_tag,
    input  logic                 commit_valid,
    input  logic                 recover_valid,
    input  logic [TAG_WIDTH-1:0] recover_tag,
    input  logic                 recover_taken,
    output logic [GHR_WIDTH-1:0] ghr_spec,
    output logic [GHR_WIDTH-1:0] ghr_arch,
    output logic [TAG_WIDTH:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 tag_err
);

    localparam logic [TAG_WIDTH:0] FULL_CNT = (TAG_WIDTH+1)'(DEPTH);

    logic [GHR_WIDTH-1:0] ckpt_q [DEPTH];
    logic                 dir_q  [DEPTH];

    logic [TAG_WIDTH-1:0] head_q, head_d;
    logic [TAG_WIDTH-1:0] tail_q, tail_d;
    logic [TAG_WIDTH:0]   count_q, count_d;
    logic [GHR_WIDTH-1:0] ghr_spec_q, ghr_spec_d;
    logic [GHR_WIDTH-1:0] ghr_arch_q, ghr_arch_d;
    logic                 tag_err_q, tag_err_d;

    logic                 alloc;
    logic                 do_commit;
    logic [TAG_WIDTH-1:0] rec_dist;
    logic                 rec_ok;
    logic                 commit_dir;

    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign pred_ready = !full && !recover_valid;
    assign pred_tag   = tail_q;
    assign ghr_spec   = ghr_spec_q;
    assign ghr_arch   = ghr_arch_q;
    assign count      = count_q;
    assign tag_err    = tag_err_q;

    assign alloc     = pred_valid && pred_ready;
    assign do_commit = commit_valid && !empty;

    // Distance from head wraps modulo DEPTH; the tag is live only if it lies inside the occupied window.
    assign rec_dist = recover_tag - head_q;
    assign rec_ok   = recover_valid && ({1'b0, rec_dist} < count_q);

    // A same-cycle recover of the oldest branch corrects the direction being retired.
    assign commit_dir = (rec_ok && (recover_tag == head_q)) ? recover_taken : dir_q[head_q];

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        ghr_spec_d = ghr_spec_q;
        ghr_arch_d = ghr_arch_q;
        tag_err_d  = tag_err_q;

        if (rec_ok) begin
            ghr_spec_d = {ckpt_q[recover_tag][GHR_WIDTH-2:0], recover_taken};
            tail_d     = recover_tag + 1'b1;
            count_d    = {1'b0, rec_dist} + 1'b1;
        end else if (alloc) begin
            ghr_spec_d = {ghr_spec_q[GHR_WIDTH-2:0], pred_taken};
            tail_d     = tail_q + 1'b1;
            count_d    = count_q + 1'b1;
        end

        if (recover_valid && !rec_ok) begin
            tag_err_d = 1'b1;
        end

        if (do_commit) begin
            ghr_arch_d = {ghr_arch_q[GHR_WIDTH-2:0], commit_dir};
            head_d     = head_q + 1'b1;
            count_d    = count_d - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ghr_spec_q <= '0;
            ghr_arch_q <= '0;
            tag_err_q  <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ghr_spec_q <= ghr_spec_d;
            ghr_arch_q <= ghr_arch_d;
            tag_err_q  <= tag_err_d;
        end
    end

    // Checkpoint storage carries no reset; entries are only read once allocated.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (alloc) begin
                ckpt_q[tail_q] <= ghr_spec_q;
                dir_q[tail_q]  <= pred_taken;
            end
            if (rec_ok) begin
                dir_q[recover_tag] <= recover_taken;
            end
        end
    end

endmodule
